// File: rtl/sparse_intersect_joiner.sv
// rtl/sparse_intersect_joiner.sv - two-fiber sparse coordinate joiner (intersect/union)
// Optional build macro INTERSECT_CYCLE_COUNT_EN adds the cycle_count output.
module sparse_intersect_joiner #(
    parameter int                DATA_W      = 17,
    parameter logic [DATA_W-1:0] DONE_TOKEN  = 17'h10100,
    parameter logic [DATA_W-1:0] EMPTY_TOKEN = 17'h10200
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              clk_en,
    input  logic              tile_en,
    input  logic              joiner_op,
    input  logic              vector_reduce_mode,
    input  logic [DATA_W-1:0] coord_in_0,
    input  logic              coord_in_0_valid,
    output logic              coord_in_0_ready,
    input  logic [DATA_W-1:0] pos_in_0,
    input  logic              pos_in_0_valid,
    output logic              pos_in_0_ready,
    input  logic [DATA_W-1:0] coord_in_1,
    input  logic              coord_in_1_valid,
    output logic              coord_in_1_ready,
    input  logic [DATA_W-1:0] pos_in_1,
    input  logic              pos_in_1_valid,
    output logic              pos_in_1_ready,
    output logic [DATA_W-1:0] coord_out,
    output logic              coord_out_valid,
    input  logic              coord_out_ready,
    output logic [DATA_W-1:0] pos_out_0,
    output logic              pos_out_0_valid,
    input  logic              pos_out_0_ready,
    output logic [DATA_W-1:0] pos_out_1,
    output logic              pos_out_1_valid,
    input  logic              pos_out_1_ready
`ifdef INTERSECT_CYCLE_COUNT_EN
    ,
    output logic [63:0]       cycle_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [DATA_W-2:0] PAY_ONE = 1;

    state_t state, state_next;

    logic [DATA_W-1:0] coord_r, pos0_r, pos1_r;
    logic              out_valid_r;

    logic              head_ok, out_fire, out_free, allow, do_emit;
    logic              a_data, b_data, a_done;
    logic [DATA_W-2:0] a_pay, b_pay;
    logic [8:0]        a_lvl, b_lvl;
    logic [DATA_W-1:0] stop_dec;

    logic              want_pop0, want_pop1, want_emit, hit_done;
    logic [DATA_W-1:0] emit_coord, emit_pos0, emit_pos1;

    assign head_ok  = coord_in_0_valid & pos_in_0_valid & coord_in_1_valid & pos_in_1_valid;
    assign out_fire = tile_en & out_valid_r & coord_out_ready & pos_out_0_ready & pos_out_1_ready;
    assign out_free = ~out_valid_r | out_fire;

    assign a_data   = ~coord_in_0[DATA_W-1];
    assign b_data   = ~coord_in_1[DATA_W-1];
    assign a_done   = (coord_in_0 == DONE_TOKEN);
    assign a_pay    = coord_in_0[DATA_W-2:0];
    assign b_pay    = coord_in_1[DATA_W-2:0];
    // done carries payload 0x100, so it ranks above every stop level 0..0xFF
    assign a_lvl    = coord_in_0[8:0];
    assign b_lvl    = coord_in_1[8:0];
    assign stop_dec = {1'b1, a_pay - PAY_ONE};

    always_comb begin
        want_pop0  = 1'b0;
        want_pop1  = 1'b0;
        want_emit  = 1'b0;
        hit_done   = 1'b0;
        emit_coord = '0;
        emit_pos0  = '0;
        emit_pos1  = '0;
        if (a_data && b_data && a_pay == b_pay) begin
            want_pop0  = 1'b1;
            want_pop1  = 1'b1;
            want_emit  = 1'b1;
            emit_coord = coord_in_0;
            emit_pos0  = pos_in_0;
            emit_pos1  = pos_in_1;
        end else if (a_data && (!b_data || a_pay < b_pay)) begin
            want_pop0  = 1'b1;
            want_emit  = joiner_op;
            emit_coord = coord_in_0;
            emit_pos0  = pos_in_0;
            emit_pos1  = EMPTY_TOKEN;
        end else if (b_data) begin
            want_pop1  = 1'b1;
            want_emit  = joiner_op;
            emit_coord = coord_in_1;
            emit_pos0  = EMPTY_TOKEN;
            emit_pos1  = pos_in_1;
        end else if (a_lvl == b_lvl) begin
            want_pop0 = 1'b1;
            want_pop1 = 1'b1;
            if (a_done) begin
                want_emit  = 1'b1;
                hit_done   = 1'b1;
                emit_coord = DONE_TOKEN;
                emit_pos0  = DONE_TOKEN;
                emit_pos1  = DONE_TOKEN;
            end else if (!vector_reduce_mode) begin
                want_emit  = 1'b1;
                emit_coord = coord_in_0;
                emit_pos0  = coord_in_0;
                emit_pos1  = coord_in_0;
            end else begin
                // flattening: S0 vanishes, Sk becomes S(k-1)
                want_emit  = (a_lvl != 9'd0);
                emit_coord = stop_dec;
                emit_pos0  = stop_dec;
                emit_pos1  = stop_dec;
            end
        end else if (a_lvl < b_lvl) begin
            want_pop0 = 1'b1;
        end else begin
            want_pop1 = 1'b1;
        end
    end

    // skips ignore output back-pressure; emitting pops need a free output slot
    assign allow   = (state == S_RUN) & tile_en & clk_en & head_ok & (~want_emit | out_free);
    assign do_emit = allow & want_emit;

    assign coord_in_0_ready = allow & want_pop0;
    assign pos_in_0_ready   = allow & want_pop0;
    assign coord_in_1_ready = allow & want_pop1;
    assign pos_in_1_ready   = allow & want_pop1;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (tile_en) state_next = S_RUN;
            S_RUN:   if (do_emit && hit_done) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state <= S_IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            out_valid_r <= 1'b0;
            coord_r     <= '0;
            pos0_r      <= '0;
            pos1_r      <= '0;
        end else if (clk_en) begin
            if (do_emit) begin
                out_valid_r <= 1'b1;
                coord_r     <= emit_coord;
                pos0_r      <= emit_pos0;
                pos1_r      <= emit_pos1;
            end else if (out_fire) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign coord_out       = coord_r;
    assign pos_out_0       = pos0_r;
    assign pos_out_1       = pos1_r;
    assign coord_out_valid = out_valid_r & tile_en;
    assign pos_out_0_valid = out_valid_r & tile_en;
    assign pos_out_1_valid = out_valid_r & tile_en;

`ifdef INTERSECT_CYCLE_COUNT_EN
    logic cc_started, cc_stopped, any_in_valid;

    assign any_in_valid = coord_in_0_valid | pos_in_0_valid | coord_in_1_valid | pos_in_1_valid;

    // the cycle in which done is accepted is not itself counted
    always_ff @(posedge clk) begin
        if (flush) begin
            cycle_count <= '0;
            cc_started  <= 1'b0;
            cc_stopped  <= 1'b0;
        end else if (clk_en && !cc_stopped && (cc_started || any_in_valid)) begin
            cc_started <= 1'b1;
            if (out_fire && pos0_r == DONE_TOKEN) begin
                cc_stopped <= 1'b1;
            end else begin
                cycle_count <= cycle_count + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sparse_intersect_joiner.sv
// tb/tb_sparse_intersect_joiner.sv - randomized self-checking bench for sparse_intersect_joiner
module tb_sparse_intersect_joiner;

    localparam logic [16:0] DONE  = 17'h10100;
    localparam logic [16:0] EMPTY = 17'h10200;
    localparam logic [16:0] S0    = 17'h10000;
    localparam logic [16:0] S1    = 17'h10001;

    logic        clk = 1'b0;
    logic        flush, clk_en, tile_en, joiner_op, vector_reduce_mode;
    logic [16:0] coord_in_0, pos_in_0, coord_in_1, pos_in_1;
    logic        coord_in_0_valid, pos_in_0_valid, coord_in_1_valid, pos_in_1_valid;
    logic        coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready;
    logic [16:0] coord_out, pos_out_0, pos_out_1;
    logic        coord_out_valid, pos_out_0_valid, pos_out_1_valid;
    logic        coord_out_ready, pos_out_0_ready, pos_out_1_ready;
`ifdef INTERSECT_CYCLE_COUNT_EN
    logic [63:0] cycle_count;
`endif

    always #5 clk = ~clk;

    sparse_intersect_joiner dut (
        .clk                (clk),
        .flush              (flush),
        .clk_en             (clk_en),
        .tile_en            (tile_en),
        .joiner_op          (joiner_op),
        .vector_reduce_mode (vector_reduce_mode),
        .coord_in_0         (coord_in_0),
        .coord_in_0_valid   (coord_in_0_valid),
        .coord_in_0_ready   (coord_in_0_ready),
        .pos_in_0           (pos_in_0),
        .pos_in_0_valid     (pos_in_0_valid),
        .pos_in_0_ready     (pos_in_0_ready),
        .coord_in_1         (coord_in_1),
        .coord_in_1_valid   (coord_in_1_valid),
        .coord_in_1_ready   (coord_in_1_ready),
        .pos_in_1           (pos_in_1),
        .pos_in_1_valid     (pos_in_1_valid),
        .pos_in_1_ready     (pos_in_1_ready),
        .coord_out          (coord_out),
        .coord_out_valid    (coord_out_valid),
        .coord_out_ready    (coord_out_ready),
        .pos_out_0          (pos_out_0),
        .pos_out_0_valid    (pos_out_0_valid),
        .pos_out_0_ready    (pos_out_0_ready),
        .pos_out_1          (pos_out_1),
        .pos_out_1_valid    (pos_out_1_valid),
        .pos_out_1_ready    (pos_out_1_ready)
`ifdef INTERSECT_CYCLE_COUNT_EN
        ,
        .cycle_count        (cycle_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] sc0[$], sp0[$], sc1[$], sp1[$];
    logic [16:0] exp_c[$], exp_p0[$], exp_p1[$];
    logic [16:0] got_c[$], got_p0[$], got_p1[$];
    int          idx0, idx1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [16:0] c, input logic [16:0] p0, input logic [16:0] p1);
        exp_c.push_back(c);
        exp_p0.push_back(p0);
        exp_p1.push_back(p1);
    endtask

    // Reference: every token is an unsigned key (data < stops by level < done).
    // Smaller key is consumed alone; equal keys are matched.
    task automatic model(input bit op, input bit vr);
        int i = 0;
        int j = 0;
        logic [16:0] a, b;
        exp_c.delete(); exp_p0.delete(); exp_p1.delete();
        while (i < sc0.size() && j < sc1.size()) begin
            a = sc0[i];
            b = sc1[j];
            if (a == b) begin
                if (!a[16]) push_exp(a, sp0[i], sp1[j]);
                else if (a == DONE) begin
                    push_exp(DONE, DONE, DONE);
                    break;
                end else if (!vr) push_exp(a, a, a);
                else if (a[7:0] != 8'd0) push_exp(a - 17'd1, a - 17'd1, a - 17'd1);
                i++;
                j++;
            end else if (a < b) begin
                if (op && !a[16]) push_exp(a, sp0[i], EMPTY);
                i++;
            end else begin
                if (op && !b[16]) push_exp(b, EMPTY, sp1[j]);
                j++;
            end
        end
    endtask

    task automatic push_tok(input int st, input logic [16:0] c, input logic [16:0] p);
        if (st == 0) begin
            sc0.push_back(c);
            sp0.push_back(p);
        end else begin
            sc1.push_back(c);
            sp1.push_back(p);
        end
    endtask

    task automatic load_fibers(input logic [16:0] a[5], input logic [16:0] b[5]);
        sc0.delete(); sp0.delete(); sc1.delete(); sp1.delete();
        for (int k = 0; k < 5; k++) begin
            push_tok(0, a[k], 17'(k));
            push_tok(1, b[k], 17'(k));
        end
    endtask

    task automatic gen_random();
        int nseg, n, shared, l1;
        logic [16:0] v;
        sc0.delete(); sp0.delete(); sc1.delete(); sp1.delete();
        nseg = $urandom_range(1, 3);
        for (int s = 0; s < nseg; s++) begin
            for (int st = 0; st < 2; st++) begin
                n = $urandom_range(0, 5);
                v = 17'($urandom_range(0, 3));
                for (int k = 0; k < n; k++) begin
                    push_tok(st, v, 17'($urandom_range(0, 65535)));
                    v = v + 17'($urandom_range(1, 3));
                end
            end
            shared = $urandom_range(0, 2);
            l1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : shared;
            push_tok(0, S0 | 17'(shared), S0 | 17'(shared));
            push_tok(1, S0 | 17'(l1), S0 | 17'(l1));
        end
        push_tok(0, DONE, DONE);
        push_tok(1, DONE, DONE);
    endtask

    task automatic drive(input bit stall);
        coord_in_0       = (idx0 < sc0.size()) ? sc0[idx0] : 17'd0;
        pos_in_0         = (idx0 < sp0.size()) ? sp0[idx0] : 17'd0;
        coord_in_1       = (idx1 < sc1.size()) ? sc1[idx1] : 17'd0;
        pos_in_1         = (idx1 < sp1.size()) ? sp1[idx1] : 17'd0;
        coord_in_0_valid = (idx0 < sc0.size()) && (!stall || $urandom_range(0, 3) != 0);
        pos_in_0_valid   = (idx0 < sc0.size()) && (!stall || $urandom_range(0, 3) != 0);
        coord_in_1_valid = (idx1 < sc1.size()) && (!stall || $urandom_range(0, 3) != 0);
        pos_in_1_valid   = (idx1 < sc1.size()) && (!stall || $urandom_range(0, 3) != 0);
        coord_out_ready  = !stall || $urandom_range(0, 3) != 0;
        pos_out_0_ready  = !stall || $urandom_range(0, 3) != 0;
        pos_out_1_ready  = !stall || $urandom_range(0, 3) != 0;
    endtask

    task automatic apply_flush();
        flush = 1'b1;
        idx0 = 1 << 20;
        idx1 = 1 << 20;
        drive(1'b0);
        repeat (2) @(posedge clk);
        #1 flush = 1'b0;
    endtask

    // One cycle: drive, observe at negedge, advance stream indices after the edge.
    int bad_pair, bad_align;
    task automatic step(input bit stall);
        bit h0, h1;
        drive(stall);
        @(negedge clk);
        h0 = coord_in_0_valid && coord_in_0_ready;
        h1 = coord_in_1_valid && coord_in_1_ready;
        if (coord_in_0_ready !== pos_in_0_ready || coord_in_1_ready !== pos_in_1_ready) bad_pair++;
        if (coord_in_0_ready && !(coord_in_0_valid && pos_in_0_valid)) bad_pair++;
        if (coord_in_1_ready && !(coord_in_1_valid && pos_in_1_valid)) bad_pair++;
        if (coord_out_valid !== pos_out_0_valid || coord_out_valid !== pos_out_1_valid) bad_align++;
        if (coord_out_valid && coord_out_ready && pos_out_0_ready && pos_out_1_ready) begin
            got_c.push_back(coord_out);
            got_p0.push_back(pos_out_0);
            got_p1.push_back(pos_out_1);
        end
        @(posedge clk);
        #1;
        if (h0) idx0++;
        if (h1) idx1++;
    endtask

    task automatic run_test(input string name, input bit op, input bit vr, input bit stall,
                            input int flush_at);
        int cyc = 0;
        int m;
        joiner_op = op;
        vector_reduce_mode = vr;
        tile_en = 1'b1;
        clk_en = 1'b1;
        apply_flush();
        got_c.delete(); got_p0.delete(); got_p1.delete();
        idx0 = 0;
        idx1 = 0;
        bad_pair = 0;
        bad_align = 0;
        while (got_c.size() < exp_c.size() && cyc < 1500) begin
            step(stall);
            cyc++;
            if (flush_at != 0 && cyc == flush_at) return;
        end
        repeat (6) step(1'b0);
        coord_in_0_valid = 1'b1; pos_in_0_valid = 1'b1;
        coord_in_1_valid = 1'b1; pos_in_1_valid = 1'b1;
        @(negedge clk);
        check_eq({name, " done_hold_ready"}, 32'({coord_in_0_ready, coord_in_1_ready}), 32'd0);
        check_eq({name, " count"}, 32'(got_c.size()), 32'(exp_c.size()));
        check_eq({name, " ready_pairing"}, 32'(bad_pair), 32'd0);
        check_eq({name, " valid_align"}, 32'(bad_align), 32'd0);
        m = (got_c.size() < exp_c.size()) ? got_c.size() : exp_c.size();
        for (int k = 0; k < m; k++) begin
            check_eq($sformatf("%s coord[%0d]", name, k), 32'(got_c[k]), 32'(exp_c[k]));
            check_eq($sformatf("%s pos0[%0d]", name, k), 32'(got_p0[k]), 32'(exp_p0[k]));
            check_eq($sformatf("%s pos1[%0d]", name, k), 32'(got_p1[k]), 32'(exp_p1[k]));
        end
    endtask

    task automatic set_plan_intersect();
        load_fibers('{17'd1, 17'd3, 17'd5, S0, DONE}, '{17'd3, 17'd4, 17'd5, S0, DONE});
        exp_c  = '{17'd3, 17'd5, S0, DONE};
        exp_p0 = '{17'd1, 17'd2, S0, DONE};
        exp_p1 = '{17'd0, 17'd2, S0, DONE};
    endtask

    task automatic set_plan_union();
        load_fibers('{17'd1, 17'd3, 17'd5, S0, DONE}, '{17'd3, 17'd4, 17'd5, S0, DONE});
        exp_c  = '{17'd1, 17'd3, 17'd4, 17'd5, S0, DONE};
        exp_p0 = '{17'd0, 17'd1, EMPTY, 17'd2, S0, DONE};
        exp_p1 = '{EMPTY, 17'd0, 17'd1, 17'd2, S0, DONE};
    endtask

    initial begin
        bit op, vr, st;
        flush = 1'b1;
        clk_en = 1'b1;
        tile_en = 1'b1;
        joiner_op = 1'b0;
        vector_reduce_mode = 1'b0;
        coord_in_0 = 17'd7; pos_in_0 = 17'd7; coord_in_1 = 17'd7; pos_in_1 = 17'd7;
        coord_in_0_valid = 1'b1; pos_in_0_valid = 1'b1;
        coord_in_1_valid = 1'b1; pos_in_1_valid = 1'b1;
        coord_out_ready = 1'b1; pos_out_0_ready = 1'b1; pos_out_1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset out_valids", 32'({coord_out_valid, pos_out_0_valid, pos_out_1_valid}), 32'd0);
        check_eq("reset in_readys", 32'({coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}), 32'd0);
        check_eq("reset coord_out", 32'(coord_out), 32'd0);
        check_eq("reset pos_out_0", 32'(pos_out_0), 32'd0);
        check_eq("reset pos_out_1", 32'(pos_out_1), 32'd0);

        @(posedge clk);
        #1;
        flush = 1'b0;
        tile_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("tile_off in_readys", 32'({coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}), 32'd0);
        check_eq("tile_off out_valid", 32'(coord_out_valid), 32'd0);

        set_plan_intersect();
        run_test("isect", 1'b0, 1'b0, 1'b0, 0);
        set_plan_union();
        run_test("union", 1'b1, 1'b0, 1'b0, 0);
        set_plan_intersect();
        run_test("isect_stall", 1'b0, 1'b0, 1'b1, 0);
        set_plan_union();
        run_test("union_stall", 1'b1, 1'b0, 1'b1, 0);

        load_fibers('{17'd2, S0, 17'd7, S1, DONE}, '{17'd2, S0, 17'd7, S1, DONE});
        exp_c  = '{17'd2, 17'd7, S0, DONE};
        exp_p0 = '{17'd0, 17'd2, S0, DONE};
        exp_p1 = '{17'd0, 17'd2, S0, DONE};
        run_test("vreduce", 1'b0, 1'b1, 1'b0, 0);

        set_plan_intersect();
        run_test("pre_flush", 1'b0, 1'b0, 1'b1, 4);
        set_plan_intersect();
        run_test("replay", 1'b0, 1'b0, 1'b0, 0);

        for (int t = 0; t < 24; t++) begin
            op = 1'($urandom_range(0, 1));
            vr = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) != 0);
            gen_random();
            model(op, vr);
            run_test($sformatf("rand%0d", t), op, vr, st, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
